// File: rtl/mips_cpu_bus_arbiter_pkg.sv
// Shared types for the bus arbiter that multiplexes fetch and load/store onto one Avalon-MM master.
package mips_cpu_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS_I = 2'd1,
      BUS_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   localparam logic [3:0]  BYTEEN_ALL    = 4'b1111;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter between fetch (I) and data (D) onto one registered Avalon-MM master,
// one transaction at a time, with a waitrequest watchdog that aborts after MAX_WAIT cycles.
module mips_cpu_bus_arbiter
   import mips_cpu_bus_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byteen,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        timeout,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   localparam int            CW        = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

   arb_state_t    r_state,      w_state_nxt;
   grant_t        r_last_grant, w_last_grant_nxt;
   logic [CW-1:0] r_wait_cnt,   w_wait_cnt_nxt;
   logic [31:0]   r_address,    w_address_nxt;
   logic          r_read,       w_read_nxt;
   logic          r_write,      w_write_nxt;
   logic [3:0]    r_byteen,     w_byteen_nxt;
   logic [31:0]   r_wdata,      w_wdata_nxt;
   logic          r_i_done,     w_i_done_nxt;
   logic          r_d_done,     w_d_done_nxt;
   logic [31:0]   r_i_rdata,    w_i_rdata_nxt;
   logic [31:0]   r_d_rdata,    w_d_rdata_nxt;
   logic          r_timeout,    w_timeout_nxt;
   logic          w_i_ok;
   logic          w_d_ok;
   logic          w_pick_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= GRANT_I;
         r_wait_cnt   <= '0;
         r_address    <= '0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_byteen     <= '0;
         r_wdata      <= '0;
         r_i_done     <= 1'b0;
         r_d_done     <= 1'b0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_wait_cnt   <= w_wait_cnt_nxt;
         r_address    <= w_address_nxt;
         r_read       <= w_read_nxt;
         r_write      <= w_write_nxt;
         r_byteen     <= w_byteen_nxt;
         r_wdata      <= w_wdata_nxt;
         r_i_done     <= w_i_done_nxt;
         r_d_done     <= w_d_done_nxt;
         r_i_rdata    <= w_i_rdata_nxt;
         r_d_rdata    <= w_d_rdata_nxt;
         r_timeout    <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      w_wait_cnt_nxt   = r_wait_cnt;
      w_address_nxt    = r_address;
      w_read_nxt       = r_read;
      w_write_nxt      = r_write;
      w_byteen_nxt     = r_byteen;
      w_wdata_nxt      = r_wdata;
      w_i_done_nxt     = 1'b0;
      w_d_done_nxt     = 1'b0;
      w_i_rdata_nxt    = r_i_rdata;
      w_d_rdata_nxt    = r_d_rdata;
      w_timeout_nxt    = r_timeout;
      // A requester whose done is high this cycle must re-present before it is granted again.
      w_i_ok           = i_req && !r_i_done;
      w_d_ok           = d_req && !r_d_done;
      w_pick_d         = w_d_ok && (!w_i_ok || (r_last_grant == GRANT_I));

      case (r_state)
         IDLE: begin
            if (w_i_ok || w_d_ok) begin
               w_wait_cnt_nxt = '0;
               if (w_pick_d) begin
                  w_state_nxt      = BUS_D;
                  w_last_grant_nxt = GRANT_D;
                  w_address_nxt    = d_addr;
                  w_read_nxt       = !d_write;
                  w_write_nxt      = d_write;
                  w_byteen_nxt     = d_byteen;
                  w_wdata_nxt      = d_wdata;
               end else begin
                  w_state_nxt      = BUS_I;
                  w_last_grant_nxt = GRANT_I;
                  w_address_nxt    = i_addr;
                  w_read_nxt       = 1'b1;
                  w_write_nxt      = 1'b0;
                  w_byteen_nxt     = BYTEEN_ALL;
               end
            end
         end
         BUS_I, BUS_D: begin
            if (!waitrequest) begin
               w_state_nxt = IDLE;
               w_read_nxt  = 1'b0;
               w_write_nxt = 1'b0;
               if (r_state == BUS_I) begin
                  w_i_done_nxt  = 1'b1;
                  w_i_rdata_nxt = readdata;
               end else begin
                  w_d_done_nxt = 1'b1;
                  if (r_read) begin
                     w_d_rdata_nxt = readdata;
                  end
               end
            end else if (r_wait_cnt >= WAIT_LAST) begin
               w_state_nxt   = IDLE;
               w_read_nxt    = 1'b0;
               w_write_nxt   = 1'b0;
               w_timeout_nxt = 1'b1;
               if (r_state == BUS_I) begin
                  w_i_done_nxt  = 1'b1;
                  w_i_rdata_nxt = TIMEOUT_RDATA;
               end else begin
                  w_d_done_nxt  = 1'b1;
                  w_d_rdata_nxt = TIMEOUT_RDATA;
               end
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_read_nxt  = 1'b0;
            w_write_nxt = 1'b0;
         end
      endcase
   end

   assign i_done     = r_i_done;
   assign i_rdata    = r_i_rdata;
   assign d_done     = r_d_done;
   assign d_rdata    = r_d_rdata;
   assign timeout    = r_timeout;
   assign address    = r_address;
   assign read       = r_read;
   assign write      = r_write;
   assign byteenable = r_byteen;
   assign writedata  = r_wdata;

endmodule
